// File: rtl/generation_scheduler.sv
// rtl/generation_scheduler.sv - generation pass sequencer with run/step control and edit filtering
module generation_scheduler #(
  parameter int DATA_WIDTH   = 16,
  parameter int BOARD_W      = 512,
  parameter int BOARD_H      = 512,
  parameter int POS_WIDTH    = 9,
  parameter int ADDR_WIDTH   = 14,
  parameter int TOGGLE_DEPTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  output logic                  done_out,
  output logic                  start_out,
  input  logic                  done_in,
  output logic                  copy_mode_out,
  input  logic                  run_in,
  input  logic                  step_in,
  input  logic                  toggle_in,
  input  logic [POS_WIDTH-1:0]  toggle_x_in,
  input  logic [POS_WIDTH-1:0]  toggle_y_in,
  output logic                  toggle_ready_out,
  input  logic                  clear_in,
  input  logic [ADDR_WIDTH-1:0] addr_w_in,
  input  logic [DATA_WIDTH-1:0] data_w_in,
  input  logic                  wr_en_in,
  output logic [ADDR_WIDTH-1:0] addr_w_out,
  output logic [DATA_WIDTH-1:0] data_w_out,
  output logic                  wr_en_out,
  output logic [15:0]           gen_count_out
);

  localparam int BIT_W         = $clog2(DATA_WIDTH);
  localparam int WORDS_PER_ROW = BOARD_W / DATA_WIDTH;
  localparam int PTR_W         = (TOGGLE_DEPTH > 1) ? $clog2(TOGGLE_DEPTH) : 1;
  localparam int CNT_W         = $clog2(TOGGLE_DEPTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] fifo_addr  [TOGGLE_DEPTH];
  logic [BIT_W-1:0]      fifo_bit   [TOGGLE_DEPTH];
  logic [ADDR_WIDTH-1:0] shift_addr [TOGGLE_DEPTH];
  logic [BIT_W-1:0]      shift_bit  [TOGGLE_DEPTH];
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      active_count;
  logic [CNT_W-1:0]      pop_n;
  logic [CNT_W-1:0]      occ_after_pop;
  logic                  clear_pending;
  logic                  clear_active;
  logic                  step_pending;
  logic                  in_range;
  logic                  push_ok;
  logic                  pass_start;
  logic                  pass_end;
  logic                  evolve_now;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [BIT_W-1:0]      push_bit;
  logic [DATA_WIDTH-1:0] mask;

  assign toggle_ready_out = (count != CNT_W'(TOGGLE_DEPTH));
  assign pass_start       = (state == IDLE) && start_in;
  assign pass_end         = (state == ACTIVE) && done_in;
  assign evolve_now       = run_in || step_pending;
  assign in_range         = (32'(toggle_x_in) < BOARD_W) && (32'(toggle_y_in) < BOARD_H);
  assign push_ok          = toggle_in && toggle_ready_out && in_range && !clear_in;
  assign push_addr        = ADDR_WIDTH'(32'(toggle_y_in) * WORDS_PER_ROW + (32'(toggle_x_in) >> BIT_W));
  assign push_bit         = toggle_x_in[BIT_W-1:0];
  assign pop_n            = pass_end ? active_count : '0;
  assign occ_after_pop    = count - pop_n;

  // Head is always slot 0; popping shifts the surviving entries down.
  always_comb begin
    for (int i = 0; i < TOGGLE_DEPTH; i++) begin
      shift_addr[i] = fifo_addr[i];
      shift_bit[i]  = fifo_bit[i];
      if (i + int'(pop_n) < TOGGLE_DEPTH) begin
        shift_addr[i] = fifo_addr[PTR_W'(i + int'(pop_n))];
        shift_bit[i]  = fifo_bit[PTR_W'(i + int'(pop_n))];
      end
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < TOGGLE_DEPTH; i++) begin
      if ((CNT_W'(i) < active_count) && (fifo_addr[i] == addr_w_in)) begin
        mask = mask ^ (DATA_WIDTH'(1) << fifo_bit[i]);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count <= '0;
    end else if (clear_in) begin
      count <= '0;
    end else begin
      for (int i = 0; i < TOGGLE_DEPTH; i++) begin
        fifo_addr[i] <= shift_addr[i];
        fifo_bit[i]  <= shift_bit[i];
      end
      if (push_ok) begin
        fifo_addr[PTR_W'(occ_after_pop)] <= push_addr;
        fifo_bit[PTR_W'(occ_after_pop)]  <= push_bit;
      end
      count <= occ_after_pop + CNT_W'(push_ok);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      start_out     <= 1'b0;
      done_out      <= 1'b0;
      copy_mode_out <= 1'b1;
      gen_count_out <= '0;
      step_pending  <= 1'b0;
      clear_pending <= 1'b0;
      clear_active  <= 1'b0;
      active_count  <= '0;
    end else begin
      start_out     <= pass_start;
      done_out      <= (state == FINISH);
      step_pending  <= step_in || (step_pending && !(pass_start && evolve_now));
      clear_pending <= clear_in || (clear_pending && !pass_start);
      case (state)
        IDLE: begin
          if (start_in) begin
            copy_mode_out <= !evolve_now;
            clear_active  <= clear_pending;
            active_count  <= (clear_pending || clear_in) ? '0 : count;
            state         <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (done_in) begin
            clear_active <= 1'b0;
            active_count <= '0;
            state        <= FINISH;
          end
        end
        FINISH: begin
          if (!copy_mode_out) begin
            gen_count_out <= gen_count_out + 16'd1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A flush removes the snapshotted entries too, so none may stay active.
      if (clear_in) begin
        active_count <= '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_w_out <= '0;
      data_w_out <= '0;
      wr_en_out  <= 1'b0;
    end else begin
      addr_w_out <= addr_w_in;
      data_w_out <= clear_active ? '0 : (data_w_in ^ mask);
      wr_en_out  <= wr_en_in;
    end
  end

endmodule

// File: tb/tb_generation_scheduler.sv
// tb/tb_generation_scheduler.sv - scoreboard bench for generation_scheduler
module tb_generation_scheduler;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic        done_out;
  logic        start_out;
  logic        done_in = 1'b0;
  logic        copy_mode_out;
  logic        run_in = 1'b0;
  logic        step_in = 1'b0;
  logic        toggle_in = 1'b0;
  logic [8:0]  toggle_x_in = '0;
  logic [8:0]  toggle_y_in = '0;
  logic        toggle_ready_out;
  logic        clear_in = 1'b0;
  logic [13:0] addr_w_in = '0;
  logic [15:0] data_w_in = '0;
  logic        wr_en_in = 1'b0;
  logic [13:0] addr_w_out;
  logic [15:0] data_w_out;
  logic        wr_en_out;
  logic [15:0] gen_count_out;

  typedef struct {
    logic [13:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t sb[$];
  int  total = 0;
  int  bad = 0;

  generation_scheduler dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .start_in         (start_in),
    .done_out         (done_out),
    .start_out        (start_out),
    .done_in          (done_in),
    .copy_mode_out    (copy_mode_out),
    .run_in           (run_in),
    .step_in          (step_in),
    .toggle_in        (toggle_in),
    .toggle_x_in      (toggle_x_in),
    .toggle_y_in      (toggle_y_in),
    .toggle_ready_out (toggle_ready_out),
    .clear_in         (clear_in),
    .addr_w_in        (addr_w_in),
    .data_w_in        (data_w_in),
    .wr_en_in         (wr_en_in),
    .addr_w_out       (addr_w_out),
    .data_w_out       (data_w_out),
    .wr_en_out        (wr_en_out),
    .gen_count_out    (gen_count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst_in && wr_en_out) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(addr_w_out), 32'(e.addr));
        check("wr_data", 32'(data_w_out), 32'(e.data));
      end
    end
  end

  task automatic toggle(input logic [8:0] x, input logic [8:0] y);
    tick();
    toggle_in   = 1'b1;
    toggle_x_in = x;
    toggle_y_in = y;
    tick();
    toggle_in = 1'b0;
  endtask

  task automatic pulse_clear();
    tick();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
  endtask

  task automatic start_pass(input logic exp_copy);
    tick();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check("start_out_pulse", 32'(start_out), 32'd1);
    check("copy_mode_start", 32'(copy_mode_out), 32'(exp_copy));
    tick();
    check("start_out_low", 32'(start_out), 32'd0);
  endtask

  task automatic wr(input logic [13:0] addr, input logic [15:0] din, input logic [15:0] dexp);
    wr_t e;
    tick();
    wr_en_in  = 1'b1;
    addr_w_in = addr;
    data_w_in = din;
    e.addr = addr;
    e.data = dexp;
    sb.push_back(e);
  endtask

  task automatic finish_pass(input logic exp_copy);
    tick();
    wr_en_in = 1'b0;
    done_in  = 1'b1;
    tick();
    done_in = 1'b0;
    check("done_out_early", 32'(done_out), 32'd0);
    check("copy_mode_held", 32'(copy_mode_out), 32'(exp_copy));
    tick();
    check("done_out_pulse", 32'(done_out), 32'd1);
    tick();
    check("done_out_low", 32'(done_out), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    rst_in = 1'b0;
    check("rst_done_out", 32'(done_out), 32'd0);
    check("rst_start_out", 32'(start_out), 32'd0);
    check("rst_toggle_ready", 32'(toggle_ready_out), 32'd1);
    check("rst_copy_mode", 32'(copy_mode_out), 32'd1);
    check("rst_gen_count", 32'(gen_count_out), 32'd0);
    check("rst_wr_en", 32'(wr_en_out), 32'd0);

    // free-running evolution
    run_in = 1'b1;
    for (int p = 0; p < 3; p++) begin
      start_pass(1'b0);
      repeat (8) tick();
      finish_pass(1'b0);
    end
    check("run_gen_count", 32'(gen_count_out), 32'd3);
    run_in = 1'b0;

    // single toggle at (17,2) lands in word 65, bit 1
    toggle(9'd17, 9'd2);
    start_pass(1'b1);
    wr(14'd64, 16'h1234, 16'h1234);
    wr(14'd65, 16'h0000, 16'h0002);
    finish_pass(1'b1);
    check("copy_gen_count", 32'(gen_count_out), 32'd3);

    // double toggle on one cell cancels
    toggle(9'd3, 9'd0);
    toggle(9'd3, 9'd0);
    start_pass(1'b1);
    wr(14'd0, 16'h00FF, 16'h00FF);
    finish_pass(1'b1);

    // FIFO full: fifth push dropped
    for (int k = 0; k < 5; k++) begin
      toggle(9'(k), 9'd0);
      check("ready_after_push", 32'(toggle_ready_out), (k < 3) ? 32'd1 : 32'd0);
    end
    start_pass(1'b1);
    wr(14'd0, 16'h0000, 16'h000F);
    finish_pass(1'b1);
    check("ready_after_pop", 32'(toggle_ready_out), 32'd1);
    start_pass(1'b1);
    wr(14'd0, 16'h0000, 16'h0000);
    finish_pass(1'b1);

    // clear flushes earlier toggles; later toggle waits for the following pass
    toggle(9'd0, 9'd0);
    pulse_clear();
    toggle(9'd1, 9'd0);
    start_pass(1'b1);
    wr(14'd0, 16'h5555, 16'h0000);
    wr(14'd100, 16'hFFFF, 16'h0000);
    finish_pass(1'b1);
    start_pass(1'b1);
    wr(14'd0, 16'h0000, 16'h0002);
    finish_pass(1'b1);

    // single step then back to copy mode
    tick();
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
    start_pass(1'b0);
    finish_pass(1'b0);
    check("step_gen_count", 32'(gen_count_out), 32'd4);
    start_pass(1'b1);
    finish_pass(1'b1);
    check("after_step_gen", 32'(gen_count_out), 32'd4);

    // reset mid-pass
    toggle(9'd5, 9'd0);
    start_pass(1'b1);
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rst_mid_no_done", 32'(done_out), 32'd0);
    end
    check("rst_mid_gen", 32'(gen_count_out), 32'd0);
    check("rst_mid_ready", 32'(toggle_ready_out), 32'd1);
    check("rst_mid_copy", 32'(copy_mode_out), 32'd1);
    start_pass(1'b1);
    wr(14'd0, 16'h0000, 16'h0000);
    finish_pass(1'b1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/generation_scheduler.md
# generation_scheduler

Sequences one generation pass of `life_logic` per `start_in` pulse from the synchronizer. It also applies queued user edits (single-cell toggles, whole-board clear) by filtering `life_logic`'s write stream into the back half of `double_buffer`. It sits between the synchronizer, `life_logic` and `double_buffer` on the 100 MHz domain, and owns run/pause/single-step control.

## Interface
- DATA_WIDTH, 16, cells per memory word
- BOARD_W, 512, board width in cells (multiple of DATA_WIDTH)
- BOARD_H, 512, board height in cells
- POS_WIDTH, 9, cell coordinate width
- ADDR_WIDTH, 14, word address width (BOARD_W*BOARD_H/DATA_WIDTH words)
- TOGGLE_DEPTH, 4, pending-toggle FIFO depth
- clk_in  in  1  system clock; one clock
- rst_in  in  1  synchronous, active-high reset
- start_in  in  1  pass request pulse from synchronizer
- done_out  out  1  pass complete pulse to synchronizer
- start_out  out  1  start pulse to life_logic
- done_in  in  1  completion pulse from life_logic
- copy_mode_out  out  1  high: life_logic writes each word unchanged instead of evolving it
- run_in  in  1  level; free-running evolution
- step_in  in  1  pulse; request one evolved generation
- toggle_in  in  1  enqueue toggle of cell (toggle_x_in, toggle_y_in)
- toggle_x_in, toggle_y_in  in  POS_WIDTH  toggle coordinates
- toggle_ready_out  out  1  FIFO not full
- clear_in  in  1  pulse; clear board at next pass
- addr_w_in, data_w_in, wr_en_in  in  ADDR_WIDTH/DATA_WIDTH/1  write port from life_logic
- addr_w_out, data_w_out, wr_en_out  out  ADDR_WIDTH/DATA_WIDTH/1  write port to double_buffer
- gen_count_out  out  16  evolved-generation counter

## Operation
- States: IDLE, ACTIVE, FINISH.
- IDLE + start_in: latch mode, snapshot edits, then -> ACTIVE.
- ACTIVE + done_in: pop active toggles, clear clear_active, then -> FINISH.
- FINISH: assert done_out for one cycle, then -> IDLE. start_in outside IDLE is ignored.
- Mode latch: copy_mode_out = !(run_in || step_pending). It is held constant for the whole pass.
- step_pending is set by step_in in any state. It is cleared at a pass start that latches evolve mode.
- gen_count_out increments by 1 (wrapping 0xFFFF -> 0) at FINISH of evolve passes only.
- Toggle push: accepted when toggle_in && toggle_ready_out && x < BOARD_W && y < BOARD_H.
  - Out-of-range coordinates are dropped silently.
  - Push while full is dropped.
- Word address = y*(BOARD_W/DATA_WIDTH) + (x >> log2(DATA_WIDTH)). Bit index = x mod DATA_WIDTH (bit 0 = lowest x).
- Snapshot at pass start:
  - clear_pending set: clear_active = 1, active_count = 0, clear_pending cleared.
  - Otherwise: active_count = current FIFO occupancy.
- Entries pushed during ACTIVE are not active until the next pass.
- clear_in flushes the FIFO immediately and sets clear_pending. clear_in and toggle_in in the same cycle: clear wins, toggle dropped.
- Write filter:
  - data_w_out = clear_active ? 0 : data_w_in XOR mask.
  - mask = XOR of one-hot bits of every active entry whose word address == addr_w_in. Two toggles on the same cell cancel.
- Pop at done_in removes exactly active_count entries from the head. A push in the same cycle is still accepted, with occupancy computed after the pop.

## Timing
- start_out: one-cycle pulse, 1 cycle after start_in is sampled in IDLE.
- copy_mode_out: valid on the start_out cycle. Stable until done_out.
- Write port: registered, latency 1 cycle. addr_w_out and wr_en_out are delayed copies of the inputs.
- done_out: 2 cycles after done_in (ACTIVE -> FINISH -> pulse).
- Reset values:
  - All outputs 0, except toggle_ready_out = 1 and copy_mode_out = 1.
  - FIFO empty, pending flags clear, state IDLE.
- Reset mid-pass: abandons the pass with no done_out and drops all edits. life_logic shares rst_in.

## Test plan
- run_in=1; three start_in pulses, life_logic model returning done 10 cycles after start -> three start_out pulses, three done_out pulses each 2 cycles after done_in, gen_count_out = 3, copy_mode_out = 0.
- run_in=0; toggle (17,2); start_in -> copy_mode_out = 1. Write to addr 65 with data 0x0000 emerges as 0x0002 one cycle later. gen_count_out unchanged.
- Toggle (3,0) twice, then start_in -> write to addr 0 with data 0x00FF passes as 0x00FF.
- Push 5 toggles with an empty FIFO -> toggle_ready_out falls after the 4th. 5th dropped. Only 4 masks applied.
- Push toggle (0,0), then clear_in, then toggle (1,0); start_in -> all writes are 0x0000. The next pass applies only toggle (1,0) (addr 0 → 0x0002).
- step_in with run_in=0, then two passes -> first pass evolve (gen_count_out +1), second pass copy mode. rst_in during ACTIVE -> no done_out, FIFO empty, gen_count_out = 0.
